// File: rtl/dispatch_scheduler.sv
// In-order dispatch from the IFQ head to the int / load-store / multiply issue queues,
// with branch-wait and local jump redirect. Define DISPATCH_STATS_EN for activity counters.
module dispatch_scheduler #(
    parameter int PC_W       = 32,
    parameter int BR_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifq_empty,
    input  logic [31:0]     ifq_inst,
    input  logic [PC_W-1:0] ifq_pc,
    output logic            ifq_rd_en,
    output logic            ifq_flush,
    input  logic [3:0]      dec_opcode,
    input  logic [4:0]      dec_shfamt,
    input  logic [31:0]     dec_imm,
    input  logic            dec_en_int,
    input  logic            dec_en_ls,
    input  logic            dec_en_mult,
    input  logic            dec_type_r,
    input  logic            dec_type_i,
    input  logic            dec_type_j,
    input  logic            dec_branch,
    input  logic            int_afull,
    input  logic            ls_afull,
    input  logic            mult_afull,
    output logic            int_wr_en,
    output logic            ls_wr_en,
    output logic            mult_wr_en,
    output logic [3:0]      disp_opcode,
    output logic [4:0]      disp_shfamt,
    output logic [31:0]     disp_imm,
    output logic [4:0]      disp_rs,
    output logic [4:0]      disp_rt,
    output logic [4:0]      disp_rd,
    output logic [PC_W-1:0] disp_pc,
    output logic            disp_type_r,
    output logic            disp_type_i,
    input  logic            br_resolve_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            err_invalid,
    output logic            err_br_timeout
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]     stat_dispatched,
    output logic [31:0]     stat_stall_full,
    output logic [31:0]     stat_stall_br
`endif
);

    typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

    localparam logic [31:0] BR_TO    = 32'(BR_TIMEOUT);
    localparam bit          BR_TO_EN = (BR_TIMEOUT != 0);

    state_t          state_q, state_d;
    logic            int_wr_en_q, int_wr_en_d;
    logic            ls_wr_en_q, ls_wr_en_d;
    logic            mult_wr_en_q, mult_wr_en_d;
    logic [3:0]      disp_opcode_q, disp_opcode_d;
    logic [4:0]      disp_shfamt_q, disp_shfamt_d;
    logic [31:0]     disp_imm_q, disp_imm_d;
    logic [4:0]      disp_rs_q, disp_rs_d;
    logic [4:0]      disp_rt_q, disp_rt_d;
    logic [4:0]      disp_rd_q, disp_rd_d;
    logic [PC_W-1:0] disp_pc_q, disp_pc_d;
    logic            disp_type_r_q, disp_type_r_d;
    logic            disp_type_i_q, disp_type_i_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic            ifq_flush_q, ifq_flush_d;
    logic            err_invalid_q, err_invalid_d;
    logic            err_br_timeout_q, err_br_timeout_d;
    logic [31:0]     br_cnt_q, br_cnt_d;

    logic            pop;
    logic            any_wr;
    logic [PC_W-1:0] jump_pc;
    logic            unused_inst_bits;

    assign unused_inst_bits = ^ifq_inst[31:26];

    always_comb begin
        state_d          = state_q;
        pop              = 1'b0;
        int_wr_en_d      = 1'b0;
        ls_wr_en_d       = 1'b0;
        mult_wr_en_d     = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        ifq_flush_d      = 1'b0;
        err_invalid_d    = 1'b0;
        err_br_timeout_d = 1'b0;
        br_cnt_d         = '0;

        // Jump target keeps the top nibble of PC+4 and replaces the low 28 bits.
        jump_pc       = ifq_pc + PC_W'(4);
        jump_pc[27:0] = {ifq_inst[25:0], 2'b00};

        case (state_q)
            RUN: begin
                if (!ifq_empty) begin
                    if (dec_type_j) begin
                        pop              = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = jump_pc;
                        ifq_flush_d      = 1'b1;
                        state_d          = FLUSH;
                    end else if (dec_branch) begin
                        if (!int_afull) begin
                            pop         = 1'b1;
                            int_wr_en_d = 1'b1;
                            state_d     = BR_WAIT;
                        end
                    end else if (dec_en_int) begin
                        if (!int_afull) begin
                            pop         = 1'b1;
                            int_wr_en_d = 1'b1;
                        end
                    end else if (dec_en_ls) begin
                        if (!ls_afull) begin
                            pop        = 1'b1;
                            ls_wr_en_d = 1'b1;
                        end
                    end else if (dec_en_mult) begin
                        if (!mult_afull) begin
                            pop          = 1'b1;
                            mult_wr_en_d = 1'b1;
                        end
                    end else begin
                        pop           = 1'b1;
                        err_invalid_d = 1'b1;
                    end
                end
            end
            BR_WAIT: begin
                // Saturating count so the timeout pulse fires only once per wait.
                br_cnt_d = (br_cnt_q == BR_TO) ? br_cnt_q : br_cnt_q + 32'd1;
                if (BR_TO_EN && (br_cnt_q + 32'd1 == BR_TO)) begin
                    err_br_timeout_d = 1'b1;
                end
                if (br_resolve_valid) begin
                    if (br_taken) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = br_target;
                        ifq_flush_d      = 1'b1;
                        state_d          = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        any_wr        = int_wr_en_d | ls_wr_en_d | mult_wr_en_d;
        disp_opcode_d = any_wr ? dec_opcode     : disp_opcode_q;
        disp_shfamt_d = any_wr ? dec_shfamt     : disp_shfamt_q;
        disp_imm_d    = any_wr ? dec_imm        : disp_imm_q;
        disp_rs_d     = any_wr ? ifq_inst[25:21] : disp_rs_q;
        disp_rt_d     = any_wr ? ifq_inst[20:16] : disp_rt_q;
        disp_rd_d     = any_wr ? ifq_inst[15:11] : disp_rd_q;
        disp_pc_d     = any_wr ? ifq_pc         : disp_pc_q;
        disp_type_r_d = any_wr ? dec_type_r     : disp_type_r_q;
        disp_type_i_d = any_wr ? dec_type_i     : disp_type_i_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            int_wr_en_q      <= 1'b0;
            ls_wr_en_q       <= 1'b0;
            mult_wr_en_q     <= 1'b0;
            disp_opcode_q    <= '0;
            disp_shfamt_q    <= '0;
            disp_imm_q       <= '0;
            disp_rs_q        <= '0;
            disp_rt_q        <= '0;
            disp_rd_q        <= '0;
            disp_pc_q        <= '0;
            disp_type_r_q    <= 1'b0;
            disp_type_i_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ifq_flush_q      <= 1'b0;
            err_invalid_q    <= 1'b0;
            err_br_timeout_q <= 1'b0;
            br_cnt_q         <= '0;
        end else begin
            state_q          <= state_d;
            int_wr_en_q      <= int_wr_en_d;
            ls_wr_en_q       <= ls_wr_en_d;
            mult_wr_en_q     <= mult_wr_en_d;
            disp_opcode_q    <= disp_opcode_d;
            disp_shfamt_q    <= disp_shfamt_d;
            disp_imm_q       <= disp_imm_d;
            disp_rs_q        <= disp_rs_d;
            disp_rt_q        <= disp_rt_d;
            disp_rd_q        <= disp_rd_d;
            disp_pc_q        <= disp_pc_d;
            disp_type_r_q    <= disp_type_r_d;
            disp_type_i_q    <= disp_type_i_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            ifq_flush_q      <= ifq_flush_d;
            err_invalid_q    <= err_invalid_d;
            err_br_timeout_q <= err_br_timeout_d;
            br_cnt_q         <= br_cnt_d;
        end
    end

    assign ifq_rd_en      = pop;
    assign ifq_flush      = ifq_flush_q;
    assign int_wr_en      = int_wr_en_q;
    assign ls_wr_en       = ls_wr_en_q;
    assign mult_wr_en     = mult_wr_en_q;
    assign disp_opcode    = disp_opcode_q;
    assign disp_shfamt    = disp_shfamt_q;
    assign disp_imm       = disp_imm_q;
    assign disp_rs        = disp_rs_q;
    assign disp_rt        = disp_rt_q;
    assign disp_rd        = disp_rd_q;
    assign disp_pc        = disp_pc_q;
    assign disp_type_r    = disp_type_r_q;
    assign disp_type_i    = disp_type_i_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign err_invalid    = err_invalid_q;
    assign err_br_timeout = err_br_timeout_q;

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_dispatched_q, stat_dispatched_d;
    logic [31:0] stat_stall_full_q, stat_stall_full_d;
    logic [31:0] stat_stall_br_q, stat_stall_br_d;

    always_comb begin
        stat_dispatched_d = stat_dispatched_q + {31'd0, any_wr};
        stat_stall_full_d = stat_stall_full_q
                          + {31'd0, (state_q == RUN) && !ifq_empty && !pop};
        stat_stall_br_d   = stat_stall_br_q + {31'd0, state_q == BR_WAIT};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dispatched_q <= '0;
            stat_stall_full_q <= '0;
            stat_stall_br_q   <= '0;
        end else begin
            stat_dispatched_q <= stat_dispatched_d;
            stat_stall_full_q <= stat_stall_full_d;
            stat_stall_br_q   <= stat_stall_br_d;
        end
    end

    assign stat_dispatched = stat_dispatched_q;
    assign stat_stall_full = stat_stall_full_q;
    assign stat_stall_br   = stat_stall_br_q;
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Table-driven bench for dispatch_scheduler: per-cycle vectors plus hand sequences
// for reset inside BR_WAIT and the branch-wait timeout.
module tb_dispatch_scheduler;

    localparam int T = 12;

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_LDW  = 32'h8C850008;
    localparam logic [31:0] I_MULT = 32'h00C70018;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_BEQ  = 32'h10220004;
    localparam logic [31:0] I_BAD  = 32'hFC000000;

    // {j, b, en_int, en_ls, en_mult, type_r, type_i}
    localparam logic [6:0] F_ADD = 7'b0010010;
    localparam logic [6:0] F_LDW = 7'b0001001;
    localparam logic [6:0] F_MUL = 7'b0000110;
    localparam logic [6:0] F_J   = 7'b1000000;
    localparam logic [6:0] F_BEQ = 7'b0110001;
    localparam logic [6:0] F_BAD = 7'b0000000;

    localparam logic [14:0] R_ADD = {5'd1, 5'd2, 5'd3};
    localparam logic [14:0] R_LDW = {5'd4, 5'd5, 5'd0};
    localparam logic [14:0] R_MUL = {5'd6, 5'd7, 5'd0};
    localparam logic [14:0] R_BEQ = {5'd1, 5'd2, 5'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        ifq_empty;
    logic [31:0] ifq_inst, ifq_pc;
    logic        ifq_rd_en, ifq_flush;
    logic [3:0]  dec_opcode;
    logic [4:0]  dec_shfamt;
    logic [31:0] dec_imm;
    logic        dec_en_int, dec_en_ls, dec_en_mult;
    logic        dec_type_r, dec_type_i, dec_type_j, dec_branch;
    logic        int_afull, ls_afull, mult_afull;
    logic        int_wr_en, ls_wr_en, mult_wr_en;
    logic [3:0]  disp_opcode;
    logic [4:0]  disp_shfamt;
    logic [31:0] disp_imm;
    logic [4:0]  disp_rs, disp_rt, disp_rd;
    logic [31:0] disp_pc;
    logic        disp_type_r, disp_type_i;
    logic        br_resolve_valid, br_taken;
    logic [31:0] br_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        err_invalid, err_br_timeout;
`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_dispatched, stat_stall_full, stat_stall_br;
`endif

    dispatch_scheduler #(.PC_W(32), .BR_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .ifq_empty(ifq_empty), .ifq_inst(ifq_inst), .ifq_pc(ifq_pc),
        .ifq_rd_en(ifq_rd_en), .ifq_flush(ifq_flush),
        .dec_opcode(dec_opcode), .dec_shfamt(dec_shfamt), .dec_imm(dec_imm),
        .dec_en_int(dec_en_int), .dec_en_ls(dec_en_ls), .dec_en_mult(dec_en_mult),
        .dec_type_r(dec_type_r), .dec_type_i(dec_type_i),
        .dec_type_j(dec_type_j), .dec_branch(dec_branch),
        .int_afull(int_afull), .ls_afull(ls_afull), .mult_afull(mult_afull),
        .int_wr_en(int_wr_en), .ls_wr_en(ls_wr_en), .mult_wr_en(mult_wr_en),
        .disp_opcode(disp_opcode), .disp_shfamt(disp_shfamt), .disp_imm(disp_imm),
        .disp_rs(disp_rs), .disp_rt(disp_rt), .disp_rd(disp_rd), .disp_pc(disp_pc),
        .disp_type_r(disp_type_r), .disp_type_i(disp_type_i),
        .br_resolve_valid(br_resolve_valid), .br_taken(br_taken), .br_target(br_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .err_invalid(err_invalid), .err_br_timeout(err_br_timeout)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_dispatched(stat_dispatched), .stat_stall_full(stat_stall_full),
        .stat_stall_br(stat_stall_br)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        emp;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [6:0]  fl;
        logic [2:0]  af;      // {int, ls, mult}
        logic        brv;
        logic        brt;
        logic [31:0] brtg;
        logic        x_rd;
        logic [2:0]  x_wr;    // {int, ls, mult}
        logic        x_redir;
        logic        x_flush;
        logic        x_errinv;
        logic [31:0] x_rpc;
        logic [3:0]  x_op;
        logic [14:0] x_regs;
        logic [31:0] x_pc;
    } vec_t;

    vec_t vt[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t v(string nm, logic emp, logic [31:0] inst, logic [31:0] pc,
                               logic [3:0] op, logic [6:0] fl, logic [2:0] af,
                               logic brv, logic brt, logic [31:0] brtg,
                               logic x_rd, logic [2:0] x_wr, logic x_redir, logic x_flush,
                               logic x_errinv, logic [31:0] x_rpc, logic [3:0] x_op,
                               logic [14:0] x_regs, logic [31:0] x_pc);
        vec_t r;
        r.nm = nm; r.emp = emp; r.inst = inst; r.pc = pc; r.op = op; r.fl = fl; r.af = af;
        r.brv = brv; r.brt = brt; r.brtg = brtg;
        r.x_rd = x_rd; r.x_wr = x_wr; r.x_redir = x_redir; r.x_flush = x_flush;
        r.x_errinv = x_errinv; r.x_rpc = x_rpc; r.x_op = x_op; r.x_regs = x_regs; r.x_pc = x_pc;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic emp, logic [31:0] inst, logic [31:0] pc, logic [3:0] op,
                         logic [6:0] fl, logic [2:0] af, logic brv, logic brt,
                         logic [31:0] brtg);
        ifq_empty   = emp;
        ifq_inst    = inst;
        ifq_pc      = pc;
        dec_opcode  = op;
        dec_shfamt  = inst[10:6];
        dec_imm     = {{16{inst[15]}}, inst[15:0]};
        {dec_type_j, dec_branch, dec_en_int, dec_en_ls, dec_en_mult, dec_type_r, dec_type_i} = fl;
        {int_afull, ls_afull, mult_afull} = af;
        br_resolve_valid = brv;
        br_taken         = brt;
        br_target        = brtg;
    endtask

    task automatic apply(vec_t r);
        drive(r.emp, r.inst, r.pc, r.op, r.fl, r.af, r.brv, r.brt, r.brtg);
        #1;
        chk({r.nm, ".rd_en"}, {31'd0, ifq_rd_en}, {31'd0, r.x_rd});
        @(posedge clk);
        #1;
        chk({r.nm, ".wr"}, {29'd0, int_wr_en, ls_wr_en, mult_wr_en}, {29'd0, r.x_wr});
        chk({r.nm, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, r.x_redir});
        chk({r.nm, ".ifq_flush"}, {31'd0, ifq_flush}, {31'd0, r.x_flush});
        chk({r.nm, ".err_invalid"}, {31'd0, err_invalid}, {31'd0, r.x_errinv});
        chk({r.nm, ".err_br_timeout"}, {31'd0, err_br_timeout}, 32'd0);
        chk({r.nm, ".disp_opcode"}, {28'd0, disp_opcode}, {28'd0, r.x_op});
        chk({r.nm, ".disp_regs"}, {17'd0, disp_rs, disp_rt, disp_rd}, {17'd0, r.x_regs});
        chk({r.nm, ".disp_pc"}, disp_pc, r.x_pc);
        if (r.x_redir) chk({r.nm, ".redirect_pc"}, redirect_pc, r.x_rpc);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, ".wr"}, {29'd0, int_wr_en, ls_wr_en, mult_wr_en}, 32'd0);
        chk({nm, ".redirect"}, {31'd0, redirect_valid}, 32'd0);
        chk({nm, ".redirect_pc"}, redirect_pc, 32'd0);
        chk({nm, ".flush"}, {31'd0, ifq_flush}, 32'd0);
        chk({nm, ".errs"}, {30'd0, err_invalid, err_br_timeout}, 32'd0);
        chk({nm, ".payload_a"}, {17'd0, disp_rs, disp_rt, disp_rd}, 32'd0);
        chk({nm, ".payload_b"}, {21'd0, disp_opcode, disp_shfamt, disp_type_r, disp_type_i}, 32'd0);
        chk({nm, ".disp_imm"}, disp_imm, 32'd0);
        chk({nm, ".disp_pc"}, disp_pc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // name, emp, inst, pc, op, flags, afull, brv, brt, brtg |
        //   rd, wr, redir, flush, errinv, rpc, op, regs, pc
        vt.push_back(v("add",    0, I_ADD,  32'h00400000, 4'd2, F_ADD, 3'b000, 0,0,0, 1,3'b100,0,0,0,0, 4'd2, R_ADD, 32'h00400000));
        vt.push_back(v("ldw",    0, I_LDW,  32'h00400004, 4'd1, F_LDW, 3'b001, 0,0,0, 1,3'b010,0,0,0,0, 4'd1, R_LDW, 32'h00400004));
        vt.push_back(v("mult",   0, I_MULT, 32'h00400008, 4'd0, F_MUL, 3'b100, 0,0,0, 1,3'b001,0,0,0,0, 4'd0, R_MUL, 32'h00400008));
        for (int i = 0; i < 3; i++)
            vt.push_back(v("afull",  0, I_ADD, 32'h0040000C, 4'd2, F_ADD, 3'b100, 0,0,0, 0,3'b000,0,0,0,0, 4'd0, R_MUL, 32'h00400008));
        vt.push_back(v("afrel",  0, I_ADD,  32'h0040000C, 4'd2, F_ADD, 3'b000, 0,0,0, 1,3'b100,0,0,0,0, 4'd2, R_ADD, 32'h0040000C));
        vt.push_back(v("empty",  1, I_ADD,  32'h00400010, 4'd2, F_ADD, 3'b000, 0,0,0, 0,3'b000,0,0,0,0, 4'd2, R_ADD, 32'h0040000C));
        vt.push_back(v("jump",   0, I_J,    32'h00400000, 4'd5, F_J,   3'b000, 0,0,0, 1,3'b000,1,1,0,32'h00000040, 4'd2, R_ADD, 32'h0040000C));
        vt.push_back(v("jflush", 0, I_ADD,  32'h00400004, 4'd2, F_ADD, 3'b000, 0,0,0, 0,3'b000,0,0,0,0, 4'd2, R_ADD, 32'h0040000C));
        vt.push_back(v("jres",   0, I_ADD,  32'h00000040, 4'd2, F_ADD, 3'b000, 0,0,0, 1,3'b100,0,0,0,0, 4'd2, R_ADD, 32'h00000040));
        vt.push_back(v("beq_t",  0, I_BEQ,  32'h00000044, 4'd3, F_BEQ, 3'b000, 0,0,0, 1,3'b100,0,0,0,0, 4'd3, R_BEQ, 32'h00000044));
        for (int i = 0; i < 4; i++)
            vt.push_back(v("bwait_t", 0, I_ADD, 32'h00000048, 4'd2, F_ADD, 3'b000, 0,0,0, 0,3'b000,0,0,0,0, 4'd3, R_BEQ, 32'h00000044));
        vt.push_back(v("taken",  0, I_ADD,  32'h00000048, 4'd2, F_ADD, 3'b000, 1,1,32'h00400100, 0,3'b000,1,1,0,32'h00400100, 4'd3, R_BEQ, 32'h00000044));
        vt.push_back(v("bflush", 0, I_ADD,  32'h00000048, 4'd2, F_ADD, 3'b000, 0,0,0, 0,3'b000,0,0,0,0, 4'd3, R_BEQ, 32'h00000044));
        vt.push_back(v("bres",   0, I_ADD,  32'h00400100, 4'd2, F_ADD, 3'b000, 0,0,0, 1,3'b100,0,0,0,0, 4'd2, R_ADD, 32'h00400100));
        vt.push_back(v("beq_n",  0, I_BEQ,  32'h00400104, 4'd3, F_BEQ, 3'b000, 0,0,0, 1,3'b100,0,0,0,0, 4'd3, R_BEQ, 32'h00400104));
        for (int i = 0; i < 4; i++)
            vt.push_back(v("bwait_n", 0, I_ADD, 32'h00400108, 4'd2, F_ADD, 3'b000, 0,0,0, 0,3'b000,0,0,0,0, 4'd3, R_BEQ, 32'h00400104));
        vt.push_back(v("ntaken", 0, I_ADD,  32'h00400108, 4'd2, F_ADD, 3'b000, 1,0,32'h00000123, 0,3'b000,0,0,0,0, 4'd3, R_BEQ, 32'h00400104));
        vt.push_back(v("resume", 0, I_ADD,  32'h00400108, 4'd2, F_ADD, 3'b000, 1,1,32'h00000999, 1,3'b100,0,0,0,0, 4'd2, R_ADD, 32'h00400108));
        vt.push_back(v("invalid",0, I_BAD,  32'h0040010C, 4'd0, F_BAD, 3'b000, 0,0,0, 1,3'b000,0,0,1,0, 4'd2, R_ADD, 32'h00400108));
        vt.push_back(v("br_full",0, I_BEQ,  32'h00400110, 4'd3, F_BEQ, 3'b100, 0,0,0, 0,3'b000,0,0,0,0, 4'd2, R_ADD, 32'h00400108));
        vt.push_back(v("br_go",  0, I_BEQ,  32'h00400110, 4'd3, F_BEQ, 3'b000, 0,0,0, 1,3'b100,0,0,0,0, 4'd3, R_BEQ, 32'h00400110));

        rst = 1'b1;
        drive(1, 32'd0, 32'd0, 4'd0, 7'd0, 3'b000, 0, 0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset.rd_en", {31'd0, ifq_rd_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) apply(vt[i]);

        // Now in BR_WAIT: a taken resolve coinciding with reset must be dropped.
        rst = 1'b1;
        drive(0, I_ADD, 32'h00000500, 4'd2, F_ADD, 3'b000, 1, 1, 32'h00000777);
        @(posedge clk);
        #1;
        chk_all_zero("rst_bwait");
        @(negedge clk);
        rst = 1'b0;
        drive(0, I_ADD, 32'h00000500, 4'd2, F_ADD, 3'b000, 0, 0, 32'd0);
        #1;
        chk("post_rst.rd_en", {31'd0, ifq_rd_en}, 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst.wr", {29'd0, int_wr_en, ls_wr_en, mult_wr_en}, 32'd4);
        chk("post_rst.op", {28'd0, disp_opcode}, 32'd2);
        chk("post_rst.pc", disp_pc, 32'h00000500);
        chk("post_rst.imm", disp_imm, 32'h00001820);
        chk("post_rst.type_shf", {25'd0, disp_shfamt, disp_type_r, disp_type_i}, 32'd2);
        chk("post_rst.redirect", {31'd0, redirect_valid}, 32'd0);
        @(negedge clk);

        // Branch left unresolved: timeout pulses once after exactly T wait cycles.
        drive(0, I_BEQ, 32'h00000600, 4'd3, F_BEQ, 3'b000, 0, 0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(0, I_ADD, 32'h00000604, 4'd2, F_ADD, 3'b000, 0, 0, 32'd0);
        for (int i = 1; i <= T + 2; i++) begin
            #1;
            chk($sformatf("to_wait%0d.rd_en", i), {31'd0, ifq_rd_en}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("to_cyc%0d", i), {31'd0, err_br_timeout}, (i == T) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        drive(0, I_ADD, 32'h00000604, 4'd2, F_ADD, 3'b000, 1, 0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(0, I_ADD, 32'h00000604, 4'd2, F_ADD, 3'b000, 0, 0, 32'd0);
        #1;
        chk("to_exit.rd_en", {31'd0, ifq_rd_en}, 32'd1);
        @(posedge clk);
        #1;
        chk("to_exit.wr", {29'd0, int_wr_en, ls_wr_en, mult_wr_en}, 32'd4);
        chk("to_exit.err", {31'd0, err_br_timeout}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
